// File: rtl/idma_transfer_id_tracker_pkg.sv
// rtl/idma_transfer_id_tracker_pkg.sv - shared helpers and state encoding for the transfer-ID tracker
package idma_transfer_id_tracker_pkg;

    // Index width able to address n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [0:0] {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/idma_transfer_id_tracker_fifo.sv
// rtl/idma_transfer_id_tracker_fifo.sv - fifo_v3-style tag queue, no fall-through
module idma_transfer_id_tracker_fifo
    import idma_transfer_id_tracker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AddrDepth  = idx_width(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [AddrDepth-1:0]  usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam logic [AddrDepth:0] FullCnt = (AddrDepth + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AddrDepth-1:0]  rd_ptr_q, wr_ptr_q;
    logic [AddrDepth:0]    cnt_q;
    logic                  push_ok, pop_ok;

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    // Like fifo_v3, usage wraps to zero when full; callers combine it with full_o.
    assign usage_o = cnt_q[AddrDepth-1:0];
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/idma_transfer_id_tracker.sv
// rtl/idma_transfer_id_tracker.sv - per-stream transfer-ID issue/completion tracking for the iDMA back-end
module idma_transfer_id_tracker
    import idma_transfer_id_tracker_pkg::*;
#(
    parameter int unsigned NumStreams     = 1,
    parameter int unsigned IdCounterWidth = 32,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned StreamWidth    = idx_width(NumStreams),
    parameter type dma_req_t   = logic,
    parameter type cnt_width_t = logic [IdCounterWidth-1:0],
    parameter type stream_t    = logic [StreamWidth-1:0]
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  dma_req_t                                  req_i,
    input  logic                                      req_valid_i,
    output logic                                      req_ready_o,
    input  stream_t                                   stream_idx_i,
    output cnt_width_t                                next_id_o,
    output dma_req_t                                  be_req_o,
    output logic                                      be_req_valid_o,
    input  logic                                      be_req_ready_i,
    input  logic                                      be_rsp_valid_i,
    output logic                                      be_rsp_ready_o,
    output logic [NumStreams-1:0][IdCounterWidth-1:0] done_id_o,
    output logic [NumStreams-1:0]                     busy_o
);

    localparam int unsigned CntW = idx_width(MaxOutstanding);
    localparam logic [CntW:0] MaxCnt = (CntW + 1)'(MaxOutstanding);

    cnt_width_t     iss_q  [NumStreams];
    cnt_width_t     done_q [NumStreams];
    out_state_e     out_state_q, out_state_d;
    dma_req_t       be_req_q;
    logic           tag_full, tag_empty;
    logic [CntW-1:0] tag_usage;
    logic [CntW:0]  outstanding;
    stream_t        tag_head;
    logic           accept, complete;

    assign outstanding    = {tag_full, tag_usage};
    assign req_ready_o    = ((out_state_q == OUT_EMPTY) | be_req_ready_i) & (outstanding < MaxCnt);
    assign accept         = req_valid_i & req_ready_o;
    assign be_rsp_ready_o = ~tag_empty;
    assign complete       = be_rsp_valid_i & ~tag_empty;
    assign next_id_o      = iss_q[stream_idx_i] + 1'b1;
    assign be_req_valid_o = (out_state_q == OUT_FULL);
    assign be_req_o       = be_req_q;

    idma_transfer_id_tracker_fifo #(
        .DATA_WIDTH (StreamWidth),
        .DEPTH      (MaxOutstanding)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .usage_o (tag_usage),
        .data_i  (stream_idx_i),
        .push_i  (accept),
        .data_o  (tag_head),
        .pop_i   (complete)
    );

    // Output stage: a new accept refills the register in the same cycle it drains.
    always_comb begin
        out_state_d = out_state_q;
        case (out_state_q)
            OUT_EMPTY: if (accept) out_state_d = OUT_FULL;
            OUT_FULL:  if (be_req_ready_i && !accept) out_state_d = OUT_EMPTY;
            default:   out_state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_state_q <= OUT_EMPTY;
            be_req_q    <= '0;
        end else begin
            out_state_q <= out_state_d;
            if (accept) be_req_q <= req_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int s = 0; s < NumStreams; s++) begin
                iss_q[s]  <= '0;
                done_q[s] <= '0;
            end
        end else begin
            if (accept)   iss_q[stream_idx_i] <= iss_q[stream_idx_i] + 1'b1;
            if (complete) done_q[tag_head]    <= done_q[tag_head] + 1'b1;
        end
    end

    for (genvar g = 0; g < NumStreams; g++) begin : gen_status
        assign done_id_o[g] = done_q[g];
        assign busy_o[g]    = (iss_q[g] != done_q[g]);
    end

    // A completion with nothing in flight is dropped; flag it so the source gets looked at.
    assert property (@(posedge clk_i) disable iff (!rst_ni) be_rsp_valid_i |-> !tag_empty)
        else $warning("be_rsp_valid_i with no outstanding transfer ignored");

endmodule

// File: tb/tb_idma_transfer_id_tracker.sv
// tb/tb_idma_transfer_id_tracker.sv - self-checking bench for idma_transfer_id_tracker
module tb_idma_transfer_id_tracker;

    localparam int NS = 2;
    localparam int W  = 2;
    localparam int MO = 4;
    localparam int IDMOD = 1 << W;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [15:0]       req_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [0:0]        stream_idx_i;
    logic [W-1:0]      next_id_o;
    logic [15:0]       be_req_o;
    logic              be_req_valid_o;
    logic              be_req_ready_i;
    logic              be_rsp_valid_i;
    logic              be_rsp_ready_o;
    logic [NS-1:0][W-1:0] done_id_o;
    logic [NS-1:0]     busy_o;

    always #5 clk = ~clk;

    idma_transfer_id_tracker #(
        .NumStreams     (NS),
        .IdCounterWidth (W),
        .MaxOutstanding (MO),
        .dma_req_t      (logic [15:0])
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .stream_idx_i   (stream_idx_i),
        .next_id_o      (next_id_o),
        .be_req_o       (be_req_o),
        .be_req_valid_o (be_req_valid_o),
        .be_req_ready_i (be_req_ready_i),
        .be_rsp_valid_i (be_rsp_valid_i),
        .be_rsp_ready_o (be_rsp_ready_o),
        .done_id_o      (done_id_o),
        .busy_o         (busy_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference: issued/completed totals per stream, in-flight tags in order, pending back-end request.
    int          m_iss [NS];
    int          m_done[NS];
    int          m_tags[$];
    logic [15:0] m_held;
    bit          m_held_v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return (!m_held_v || be_req_ready_i) && (m_tags.size() < MO);
    endfunction

    task automatic check_model();
        chk("req_ready", 32'(req_ready_o), 32'(m_ready()));
        chk("next_id", 32'(next_id_o), 32'((m_iss[int'(stream_idx_i)] + 1) % IDMOD));
        chk("be_req_valid", 32'(be_req_valid_o), 32'(m_held_v));
        if (m_held_v) chk("be_req_data", 32'(be_req_o), 32'(m_held));
        chk("be_rsp_ready", 32'(be_rsp_ready_o), 32'(m_tags.size() != 0));
        for (int s = 0; s < NS; s++) begin
            chk("done_id", 32'(done_id_o[s]), 32'(m_done[s]));
            chk("busy", 32'(busy_o[s]), 32'(m_iss[s] != m_done[s]));
        end
    endtask

    task automatic drive(input bit rn, input bit v, input logic [15:0] d, input int s,
                         input bit ber, input bit rv);
        @(negedge clk);
        rst_ni         = rn;
        req_valid_i    = v;
        req_i          = d;
        stream_idx_i   = 1'(s);
        be_req_ready_i = ber;
        be_rsp_valid_i = rv;
        #1;
        check_model();
    endtask

    task automatic tick();
        bit acc, cmp;
        int t;
        @(posedge clk);
        if (!rst_ni) begin
            for (int s = 0; s < NS; s++) begin
                m_iss[s]  = 0;
                m_done[s] = 0;
            end
            m_tags.delete();
            m_held_v = 0;
        end else begin
            acc = req_valid_i && m_ready();
            cmp = be_rsp_valid_i && (m_tags.size() > 0);
            if (cmp) begin
                t = m_tags.pop_front();
                m_done[t] = (m_done[t] + 1) % IDMOD;
            end
            if (acc) begin
                m_iss[int'(stream_idx_i)] = (m_iss[int'(stream_idx_i)] + 1) % IDMOD;
                m_tags.push_back(int'(stream_idx_i));
                m_held   = req_i;
                m_held_v = 1;
            end else if (m_held_v && be_req_ready_i) begin
                m_held_v = 0;
            end
        end
    endtask

    task automatic step(input bit rn, input bit v, input logic [15:0] d, input int s,
                        input bit ber, input bit rv);
        drive(rn, v, d, s, ber, rv);
        tick();
    endtask

    initial begin
        m_held   = '0;
        m_held_v = 0;
        for (int s = 0; s < NS; s++) begin m_iss[s] = 0; m_done[s] = 0; end
        rst_ni = 0; req_valid_i = 0; req_i = '0; stream_idx_i = '0;
        be_req_ready_i = 0; be_rsp_valid_i = 0;
        tick();
        step(0, 0, 0, 0, 1, 0);

        // Reset values, then a single transfer on stream 0.
        drive(1, 0, 0, 0, 1, 0);
        chk("rst_next_id", 32'(next_id_o), 1);
        chk("rst_req_ready", 32'(req_ready_o), 1);
        chk("rst_be_valid", 32'(be_req_valid_o), 0);
        chk("rst_rsp_ready", 32'(be_rsp_ready_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_done", 32'(done_id_o), 0);
        tick();
        drive(1, 1, 16'hA5A5, 0, 1, 0);
        chk("single_next_id", 32'(next_id_o), 1);
        tick();
        drive(1, 0, 0, 0, 1, 0);
        chk("single_be_valid", 32'(be_req_valid_o), 1);
        chk("single_be_data", 32'(be_req_o), 32'h0000A5A5);
        chk("single_busy", 32'(busy_o), 1);
        tick();
        step(1, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 1, 0);
        chk("single_done", 32'(done_id_o), 1);
        chk("single_busy_clr", 32'(busy_o), 0);
        tick();

        // Interleaved streams s0,s1,s0 with in-order completions.
        step(1, 1, 16'h0101, 0, 1, 0);
        step(1, 1, 16'h0202, 1, 1, 0);
        step(1, 1, 16'h0303, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 1, 1);
        chk("ilv_busy_a", 32'(busy_o), 3);
        tick();
        drive(1, 0, 0, 0, 1, 1);
        chk("ilv_busy_b", 32'(busy_o), 1);
        tick();
        drive(1, 0, 0, 0, 1, 0);
        chk("ilv_busy_c", 32'(busy_o), 0);
        chk("ilv_done", 32'(done_id_o), 32'h7);
        tick();

        // Outstanding limit: four in flight stalls the fifth until one completes.
        for (int i = 0; i < MO; i++) step(1, 1, 16'(16'h1000 + i), 1, 1, 0);
        drive(1, 1, 16'h2000, 1, 1, 0);
        chk("lim_stall", 32'(req_ready_o), 0);
        tick();
        drive(1, 1, 16'h2000, 1, 1, 1);
        chk("lim_no_rsp_path", 32'(req_ready_o), 0);
        tick();
        drive(1, 1, 16'h2000, 1, 1, 0);
        chk("lim_release", 32'(req_ready_o), 1);
        tick();
        for (int i = 0; i < MO; i++) step(1, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 1, 0);
        chk("lim_done", 32'(done_id_o), 32'hB);
        chk("lim_busy", 32'(busy_o), 0);
        tick();

        // Back-end back-pressure; the first accept also wraps stream 0's ID to 0.
        drive(1, 1, 16'h1234, 0, 0, 0);
        chk("bp_wrap_id", 32'(next_id_o), 0);
        chk("bp_first_ready", 32'(req_ready_o), 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 16'h5678, 0, 0, 0);
            chk("bp_stall", 32'(req_ready_o), 0);
            chk("bp_hold", 32'(be_req_o), 32'h1234);
            tick();
        end
        drive(1, 1, 16'h5678, 0, 1, 0);
        chk("bp_rise_ready", 32'(req_ready_o), 1);
        chk("bp_rise_id", 32'(next_id_o), 1);
        tick();
        drive(1, 0, 0, 0, 1, 0);
        chk("bp_second", 32'(be_req_o), 32'h5678);
        tick();
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 1, 0);
        chk("bp_done", 32'(done_id_o), 32'h9);
        chk("bp_busy", 32'(busy_o), 0);
        tick();

        // Reset with three in flight and a held request; a stray completion afterwards.
        step(1, 1, 16'hAAAA, 1, 1, 0);
        step(1, 1, 16'hBBBB, 0, 1, 0);
        step(1, 1, 16'hCCCC, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 1);
        chk("mrst_be_valid", 32'(be_req_valid_o), 0);
        chk("mrst_rsp_ready", 32'(be_rsp_ready_o), 0);
        chk("mrst_busy", 32'(busy_o), 0);
        chk("mrst_done", 32'(done_id_o), 0);
        chk("mrst_next_id", 32'(next_id_o), 1);
        tick();
        drive(1, 0, 0, 0, 1, 0);
        chk("spur_done", 32'(done_id_o), 0);
        chk("spur_req_ready", 32'(req_ready_o), 1);
        tick();

        // Randomized traffic against the reference.
        for (int c = 0; c < 3000; c++) begin
            bit rv;
            rv = ($urandom_range(0, 9) < 4) && (m_tags.size() > 0 || $urandom_range(0, 15) == 0);
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 6), 16'($urandom),
                 int'($urandom_range(0, NS - 1)), ($urandom_range(0, 9) < 7), rv);
        end
        for (int c = 0; c < 2 * MO + 2; c++) step(1, 0, 0, 0, 1, (m_tags.size() > 0));
        drive(1, 0, 0, 0, 1, 0);
        chk("final_busy", 32'(busy_o), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idma_transfer_id_tracker.md
IDMA_TRANSFER_ID_TRACKER -- requirements
Module: idma_transfer_id_tracker

Interface
REQ-001 SHALL have parameter NumStreams, default 1: number of streams, 1..16.
REQ-002 SHALL have parameter IdCounterWidth, default 32: transfer-ID width, 2..32.
REQ-003 SHALL have parameter MaxOutstanding, default 8: total transfers in flight, power of two, 2..64.
REQ-004 SHALL have parameter StreamWidth, default cf_math_pkg::idx_width(NumStreams): stream index width.
REQ-005 SHALL have type parameters dma_req_t (default logic), cnt_width_t (logic [IdCounterWidth-1:0]) and stream_t (logic [StreamWidth-1:0]).
REQ-006 SHALL use one clock and a synchronous, active-low reset.
REQ-007 Port list:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  dma_req_t  front-end 1D request
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted
- stream_idx_i  in  StreamWidth  stream of the offered request
- next_id_o  out  IdCounterWidth  ID the offered request receives
- be_req_o  out  dma_req_t  request to back-end
- be_req_valid_o  out  1  back-end request valid
- be_req_ready_i  in  1  back-end ready
- be_rsp_valid_i  in  1  back-end completion, in order
- be_rsp_ready_o  out  1  completion accepted
- done_id_o  out  NumStreams x IdCounterWidth  last completed ID per stream
- busy_o  out  NumStreams  stream has outstanding transfers

Function
REQ-008 SHALL keep per-stream issue counter iss[s] and done counter done[s], both IdCounterWidth bits, wrapping modulo 2^IdCounterWidth.
REQ-009 next_id_o SHALL be combinationally iss[stream_idx_i]+1, valid regardless of req_valid_i.
REQ-010 req_ready_o SHALL be 1 iff output register empty or be_req_ready_i is 1, AND outstanding count < MaxOutstanding; no dependence on same-cycle be_rsp_valid_i.
REQ-011 On accept (req_valid_i & req_ready_o): iss[stream_idx_i] increments, stream_idx_i pushed to the tag FIFO, req_i loaded into the output register.
REQ-012 Output register SHALL be a one-entry pipeline stage: be_req_valid_o asserts the cycle after accept; be_req_o is held stable while be_req_valid_o & ~be_req_ready_i; full throughput of one request per cycle when back-end is always ready.
REQ-013 be_rsp_ready_o SHALL be 1 iff the tag FIFO is non-empty.
REQ-014 On be_rsp_valid_i & be_rsp_ready_o: pop tag t; done[t] increments next cycle.
REQ-015 Simultaneous accept and completion SHALL both take effect; outstanding count unchanged.
REQ-016 done_id_o[s] SHALL equal done[s]; busy_o[s] SHALL be (iss[s] != done[s]), registered-state only.
REQ-017 be_rsp_valid_i with empty tag FIFO SHALL be ignored (no counter change) and flagged by a simulation assertion.
REQ-018 Counter wrap: ID after 2^IdCounterWidth-1 SHALL be 0; busy_o remains correct across the wrap.

Reset
REQ-019 While rst_ni==0 at a clock edge: all iss/done = 0, tag FIFO empty, output register empty.
REQ-020 Reset outputs: be_req_valid_o=0, be_rsp_ready_o=0, busy_o=0, done_id_o=0, next_id_o=1, req_ready_o=1.
REQ-021 Reset mid-operation SHALL drop the held back-end request and all outstanding tags without completion.

Structure
REQ-022 No new package types; dma_req_t comes from the idma_pkg-based typedefs used by all front-ends.
REQ-023 The tag FIFO SHALL be one instance of common_cells fifo_v3 (DATA_WIDTH StreamWidth, DEPTH MaxOutstanding, no fall-through); outstanding count taken from its usage output plus full flag.

Verification
REQ-024 Single request stream 0 after reset: next_id_o=1 before accept; be_req_valid_o the next cycle; completion -> done_id_o[0]=1, busy_o[0]=0.
REQ-025 NumStreams=2, interleaved requests s0,s1,s0, in-order completions: done_id_o = {s0:2, s1:1}; busy cleared only after last completion per stream.
REQ-026 MaxOutstanding=4, back-end ready, no completions: 4 requests accepted, 5th holds req_ready_o=0 until one completion, then accepted the following cycle.
REQ-027 be_req_ready_i=0 for 3 cycles with a held request: be_req_o stable, req_ready_o=0; second request accepted the cycle be_req_ready_i rises.
REQ-028 IdCounterWidth=2: 5 transfers on stream 0 -> IDs 1,2,3,0,1; done_id_o[0]=1 at end, busy_o[0]=0.
REQ-029 Reset asserted with 3 outstanding and a held request: next cycle all outputs at REQ-020 values; spurious be_rsp_valid_i ignored.
